reg_share_arbiter: RTL and testbench
====================================

Name: reg_share_arbiter

Overview:
- Shares the 10-bit pipeline register between two requesters (e.g. counter path and switch path) plus a clear source.
- Arbitrates round-robin between the two requesters and captures the winner's data.
- Drives the register's data bus and issues one-cycle load and clear strobes, then enforces a hold-off before the next transaction.
- Sits directly in front of the 10-bit register; the register loads only on this block's strobes.

Parameters:
- WIDTH, 10, data width of requester and register buses.
- HOLD_CYCLES, 2, idle cycles enforced after each load/clear before the next arbitration (0 allowed).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 load request, level; held until gnt0 is seen.
- data0  input  WIDTH  requester 0 data, valid while req0 is high.
- req1  input  1  requester 1 load request, level.
- data1  input  WIDTH  requester 1 data.
- clr_req  input  1  single-cycle clear request pulse.
- gnt0  output  1  one-cycle acknowledge to requester 0.
- gnt1  output  1  one-cycle acknowledge to requester 1.
- reg_d  output  WIDTH  data bus to the register.
- reg_load  output  1  one-cycle load strobe to the register.
- reg_clr  output  1  one-cycle clear strobe to the register.
- busy  output  1  high whenever the state is not IDLE.
- last_src  output  1  index of the requester most recently granted.

Behaviour:
- Reset (rst=0, async): state IDLE, reg_d=0, reg_load=0, reg_clr=0, gnt0=gnt1=0, busy=0, last_src=1, clr_pend=0, hold counter=0.
  - Reset mid-transaction aborts immediately; any strobe in progress drops asynchronously.
  - All outputs are registered.
- States: IDLE, LOAD, CLEAR, HOLD.
- IDLE, evaluated each rising edge, in priority order:
  1. If clr_pend or clr_req: go to CLEAR and clear clr_pend.
  2. Else if exactly one of req0/req1 is high: that requester wins.
  3. Else if both are high: the requester != last_src wins (round-robin). After reset, req0 wins the first tie.
  - On a win: reg_d <= winner's data, last_src <= winner, go to LOAD.
- LOAD (exactly 1 cycle): reg_load=1; gnt of the winner =1; reg_d stable.
  - Next state is HOLD, or IDLE if HOLD_CYCLES=0.
- CLEAR (exactly 1 cycle): reg_clr=1; no gnt asserted; reg_d <= 0; last_src unchanged.
  - Next state is HOLD, or IDLE if HOLD_CYCLES=0.
- HOLD: stays exactly HOLD_CYCLES cycles, counted by a down-counter of width clog2(HOLD_CYCLES+1) (minimum 1 bit), then goes to IDLE.
  - Requests are not sampled in HOLD.
- Latency: a request sampled at edge N produces reg_load/gnt during cycle N+1. Minimum back-to-back transaction spacing is 2+HOLD_CYCLES cycles.
- clr_req arriving in LOAD, CLEAR or HOLD sets clr_pend. Multiple pulses collapse into one pending clear, serviced at the next IDLE ahead of any req.
- clr_req and a req in the same IDLE cycle: clear wins. The req stays pending (level) and is served after the clear's HOLD.
- reg_load and reg_clr are never high in the same cycle. gnt0 and gnt1 are never high in the same cycle.
- reg_d holds its last value between transactions.
- A requester that drops req before being granted is simply not served; no error is flagged.
- A requester that keeps req high after its gnt is treated as a new request at the next IDLE.

Test Plan:
- Reset then single request: rst low→high; req0=1, data0=10'h2A5 at edge N → cycle N+1: reg_load=1, gnt0=1, reg_d=10'h2A5. busy=1 for 3 cycles (HOLD_CYCLES=2), last_src=0.
- Round-robin tie: req0=req1=1 held, data0=10'h001, data1=10'h3FF → grants alternate gnt0, gnt1, gnt0 at cycles N+1, N+5, N+9. reg_d follows 001, 3FF, 001.
- Clear priority and pending: clr_req pulsed during HOLD of a req1 load, req0 high → next IDLE yields reg_clr=1, reg_d=0, no gnt. Four cycles later, gnt0 with reg_load=1.
- Simultaneous clear and request in IDLE: clr_req=1, req1=1 at the same edge → CLEAR first, gnt1 follows after HOLD. Check reg_load and reg_clr are never coincident across the run.
- HOLD_CYCLES=0 build: continuous req0 → reg_load high every other cycle, busy toggles 1/0.
- Async reset mid-LOAD: assert rst low during the reg_load cycle → reg_load, gnt0 and busy drop before the next edge; reg_d=0, last_src=1 after release.

Source files
------------

// File: rtl/reg_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit pipeline register between two load
// requesters and a clear source; issues one-cycle strobes followed by a hold-off.
module reg_share_arbiter #(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned HOLD_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] data0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             clr_req,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_load,
    output logic             reg_clr,
    output logic             busy,
    output logic             last_src
);

    localparam int unsigned CNT_W     = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int unsigned HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CLEAR = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               clr_pend_q, clr_pend_d;
    logic [WIDTH-1:0]   reg_d_q, reg_d_d;
    logic               last_src_q, last_src_d;
    logic               reg_load_q, reg_load_d;
    logic               reg_clr_q, reg_clr_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               busy_q, busy_d;
    logic               win_c;

    // State register and registered outputs; reset drops any strobe at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            clr_pend_q <= 1'b0;
            reg_d_q    <= '0;
            last_src_q <= 1'b1;
            reg_load_q <= 1'b0;
            reg_clr_q  <= 1'b0;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_pend_q <= clr_pend_d;
            reg_d_q    <= reg_d_d;
            last_src_q <= last_src_d;
            reg_load_q <= reg_load_d;
            reg_clr_q  <= reg_clr_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic; outputs are decoded from the next state so they are
    // valid in the cycle the state is occupied.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_pend_d = clr_pend_q;
        reg_d_d    = reg_d_q;
        last_src_d = last_src_q;
        win_c      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_pend_q || clr_req) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    reg_d_d    = '0;
                end else if (req0 || req1) begin
                    // Tie goes to whichever requester was not served last.
                    win_c      = (req0 && req1) ? ~last_src_q : req1;
                    state_d    = ST_LOAD;
                    last_src_d = win_c;
                    reg_d_d    = win_c ? data1 : data0;
                end
            end
            ST_LOAD, ST_CLEAR: begin
                if (clr_req) begin
                    clr_pend_d = 1'b1;
                end
                if (HOLD_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLD_INIT);
                end
            end
            ST_HOLD: begin
                if (clr_req) begin
                    clr_pend_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        reg_load_d = (state_d == ST_LOAD);
        reg_clr_d  = (state_d == ST_CLEAR);
        gnt0_d     = (state_d == ST_LOAD) && !last_src_d;
        gnt1_d     = (state_d == ST_LOAD) && last_src_d;
        busy_d     = (state_d != ST_IDLE);
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign reg_d    = reg_d_q;
    assign reg_load = reg_load_q;
    assign reg_clr  = reg_clr_q;
    assign busy     = busy_q;
    assign last_src = last_src_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter: per-cycle vector table on a HOLD_CYCLES=2
// instance, plus hand sequences for async reset and a HOLD_CYCLES=0 instance.
module tb_reg_share_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, clr_req;
    logic [9:0] data0, data1;
    logic       gnt0, gnt1, reg_load, reg_clr, busy, last_src;
    logic [9:0] reg_d;

    logic       z_req0, z_req1, z_clr_req;
    logic [9:0] z_data0, z_data1;
    logic       z_gnt0, z_gnt1, z_reg_load, z_reg_clr, z_busy, z_last_src;
    logic [9:0] z_reg_d;

    int total = 0;
    int bad   = 0;
    int viol  = 0;

    reg_share_arbiter #(.WIDTH(10), .HOLD_CYCLES(2)) u_dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1), .clr_req(clr_req),
        .gnt0(gnt0), .gnt1(gnt1), .reg_d(reg_d), .reg_load(reg_load),
        .reg_clr(reg_clr), .busy(busy), .last_src(last_src)
    );

    reg_share_arbiter #(.WIDTH(10), .HOLD_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .req0(z_req0), .data0(z_data0), .req1(z_req1), .data1(z_data1), .clr_req(z_clr_req),
        .gnt0(z_gnt0), .gnt1(z_gnt1), .reg_d(z_reg_d), .reg_load(z_reg_load),
        .reg_clr(z_reg_clr), .busy(z_busy), .last_src(z_last_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ((reg_load && reg_clr) || (gnt0 && gnt1)) viol = viol + 1;
        if ((z_reg_load && z_reg_clr) || (z_gnt0 && z_gnt1)) viol = viol + 1;
    end

    typedef struct {
        logic       rst_v;
        logic       r0;
        logic [9:0] d0;
        logic       r1;
        logic [9:0] d1;
        logic       clr;
        logic       e_load;
        logic       e_clr;
        logic       e_g0;
        logic       e_g1;
        logic [9:0] e_d;
        logic       e_busy;
        logic       e_ls;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rv, input logic r0, input logic [9:0] d0,
                                input logic r1, input logic [9:0] d1, input logic c,
                                input logic el, input logic ec, input logic eg0,
                                input logic eg1, input logic [9:0] ed, input logic eb,
                                input logic els);
        vec_t v;
        v.rst_v = rv; v.r0 = r0; v.d0 = d0; v.r1 = r1; v.d1 = d1; v.clr = c;
        v.e_load = el; v.e_clr = ec; v.e_g0 = eg0; v.e_g1 = eg1;
        v.e_d = ed; v.e_busy = eb; v.e_ls = els;
        return v;
    endfunction

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " reg_load"}, 10'(reg_load), 10'(v.e_load));
        check({tag, " reg_clr"},  10'(reg_clr),  10'(v.e_clr));
        check({tag, " gnt0"},     10'(gnt0),     10'(v.e_g0));
        check({tag, " gnt1"},     10'(gnt1),     10'(v.e_g1));
        check({tag, " reg_d"},    reg_d,         v.e_d);
        check({tag, " busy"},     10'(busy),     10'(v.e_busy));
        check({tag, " last_src"}, 10'(last_src), 10'(v.e_ls));
    endtask

    initial begin
        rst = 1'b0;
        req0 = 0; req1 = 0; clr_req = 0; data0 = '0; data1 = '0;
        z_req0 = 0; z_req1 = 0; z_clr_req = 0; z_data0 = '0; z_data1 = '0;

        // single req0
        vecs.push_back(mk(1, 1,10'h2A5, 0,10'h000, 0,  1,0,1,0,10'h2A5,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2A5,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2A5,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2A5,0,0));
        // reset, then held tie alternates 0,1,0
        vecs.push_back(mk(0, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,0,1));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  1,0,1,0,10'h001,1,0));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h001,1,0));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h001,1,0));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h001,0,0));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  1,0,0,1,10'h3FF,1,1));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h3FF,1,1));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h3FF,1,1));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  0,0,0,0,10'h3FF,0,1));
        vecs.push_back(mk(1, 1,10'h001, 1,10'h3FF, 0,  1,0,1,0,10'h001,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h001,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h001,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h001,0,0));
        // clear pulsed during HOLD of a req1 load, req0 waiting
        vecs.push_back(mk(1, 0,10'h000, 1,10'h155, 0,  1,0,0,1,10'h155,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,0,0,0,10'h155,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 1,  0,0,0,0,10'h155,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,0,0,0,10'h155,0,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,1,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  0,0,0,0,10'h000,0,1));
        vecs.push_back(mk(1, 1,10'h0AA, 0,10'h000, 0,  1,0,1,0,10'h0AA,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h0AA,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h0AA,1,0));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h0AA,0,0));
        // clear and req1 together in IDLE: clear first
        vecs.push_back(mk(1, 0,10'h000, 1,10'h2C3, 1,  0,1,0,0,10'h000,1,0));
        vecs.push_back(mk(1, 0,10'h000, 1,10'h2C3, 0,  0,0,0,0,10'h000,1,0));
        vecs.push_back(mk(1, 0,10'h000, 1,10'h2C3, 0,  0,0,0,0,10'h000,1,0));
        vecs.push_back(mk(1, 0,10'h000, 1,10'h2C3, 0,  0,0,0,0,10'h000,0,0));
        vecs.push_back(mk(1, 0,10'h000, 1,10'h2C3, 0,  1,0,0,1,10'h2C3,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2C3,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2C3,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h2C3,0,1));
        // repeated clear pulses collapse into a single pending clear
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 1,  0,1,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 1,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 1,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,0,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,1,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,1,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,0,1));
        vecs.push_back(mk(1, 0,10'h000, 0,10'h000, 0,  0,0,0,0,10'h000,0,1));

        repeat (2) @(posedge clk);
        #1;
        check_all("reset", mk(0, 0,10'h000, 0,10'h000, 0, 0,0,0,0,10'h000,0,1));
        rst = 1'b1;

        foreach (vecs[i]) begin
            rst     = vecs[i].rst_v;
            req0    = vecs[i].r0;
            data0   = vecs[i].d0;
            req1    = vecs[i].r1;
            data1   = vecs[i].d1;
            clr_req = vecs[i].clr;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i]);
        end

        // async reset during the load cycle
        req0 = 1; data0 = 10'h3A1;
        @(posedge clk);
        #1;
        check("arst pre reg_load", 10'(reg_load), 10'd1);
        check("arst pre reg_d", reg_d, 10'h3A1);
        #1;
        rst = 1'b0;
        #1;
        check("arst reg_load", 10'(reg_load), 10'd0);
        check("arst gnt0", 10'(gnt0), 10'd0);
        check("arst busy", 10'(busy), 10'd0);
        check("arst reg_d", reg_d, 10'h000);
        check("arst last_src", 10'(last_src), 10'd1);
        req0 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("arst idle busy", 10'(busy), 10'd0);
        check("arst idle last_src", 10'(last_src), 10'd1);

        // zero-hold build: continuous req0 loads every other cycle
        z_req0 = 1; z_data0 = 10'h1C7;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("h0 load%0d", i), 10'(z_reg_load), 10'((i % 2) == 0));
            check($sformatf("h0 busy%0d", i), 10'(z_busy), 10'((i % 2) == 0));
            check($sformatf("h0 gnt0_%0d", i), 10'(z_gnt0), 10'((i % 2) == 0));
            check($sformatf("h0 reg_d%0d", i), z_reg_d, 10'h1C7);
        end
        z_req0 = 0;
        @(posedge clk);
        #1;

        check("strobe overlap count", 10'(viol), 10'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
